// File: rtl/noise_pkg.sv
// ---------------------------------------------------------------------------
// noise_pkg
// Shared definitions for the noise window detector:
//   - state_t        : FSM state encoding (also exported on debug_state)
//   - DEF_*          : default window length, counter width and thresholds
//   - ARM_CYCLES     : synchroniser flush time before a window opens
//   - WIN_CNT_W      : width of the in-window cycle counter (covers 4..65535)
// No ports; imported by comp_sync and noise_window_detector.
// ---------------------------------------------------------------------------
package noise_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_EVAL  = 2'd3
    } state_t;

    localparam int unsigned DEF_WINDOW_CYCLES = 1000;
    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned DEF_THRESH_HI     = 8;
    localparam int unsigned DEF_THRESH_LO     = 4;

    localparam int unsigned ARM_CYCLES        = 2;
    localparam int unsigned WIN_CNT_W         = 16;

endpackage

// File: rtl/comp_sync.sv
// ---------------------------------------------------------------------------
// comp_sync
// Two-flop synchroniser followed by a rising-edge detector for the raw
// diode comparator output.
//   clk        : system clock
//   reset      : synchronous, active-high; clears all three flops
//   async_in   : comparator output, asynchronous to clk
//   rise_pulse : one-cycle pulse, high in the cycle after the second
//                synchroniser flop first sees the input high
// A rise of async_in is therefore consumed by a register on the third clk
// edge after it occurs.
// ---------------------------------------------------------------------------
module comp_sync
    import noise_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign rise_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/noise_window_detector.sv
// ---------------------------------------------------------------------------
// noise_window_detector
// Counts rising edges of a diode comparator over fixed windows of
// WINDOW_CYCLES clocks and turns the count into a registered noise decision.
//
// Ports:
//   clk          : system clock
//   reset        : synchronous, active-high; overrides every other input
//   enable       : level-sensitive run request
//   comp_in      : raw comparator output (asynchronous)
//   noise_valid  : registered noise decision
//   window_done  : one-cycle strobe on the cycle the decision updates
//   pulse_count  : saturated edge count of the last completed window
//   debug_state  : current FSM state (IDLE=0, ARM=1, COUNT=2, EVAL=3)
//
// Build option:
//   NOISE_HYST_EN : when defined, noise_valid sets at count >= THRESH_HI,
//                   clears at count < THRESH_LO and holds in between.
//                   Otherwise noise_valid = (count >= THRESH_HI) and
//                   THRESH_LO only takes part in the parameter sanity check.
//
// Window timeline after enable is sampled in IDLE: 2 ARM cycles, then
// WINDOW_CYCLES COUNT cycles, then 1 EVAL cycle, after which COUNT/EVAL
// repeat. Thresholds compare unsigned at CNT_W bits.
// ---------------------------------------------------------------------------
module noise_window_detector
    import noise_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned THRESH_HI     = DEF_THRESH_HI,
    parameter int unsigned THRESH_LO     = DEF_THRESH_LO
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             comp_in,
    output logic             noise_valid,
    output logic             window_done,
    output logic [CNT_W-1:0] pulse_count,
    output logic [1:0]       debug_state
);

    if (WINDOW_CYCLES < 4 || WINDOW_CYCLES > 65535 || THRESH_LO > THRESH_HI) begin : g_bad_params
        $error("noise_window_detector: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0]     THI_C      = CNT_W'(THRESH_HI);
`ifdef NOISE_HYST_EN
    localparam logic [CNT_W-1:0]     TLO_C      = CNT_W'(THRESH_LO);
`endif
    localparam logic [WIN_CNT_W-1:0] WIN_LAST_C = WIN_CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_CNT_W-1:0] ARM_LAST_C = WIN_CNT_W'(ARM_CYCLES - 1);

    state_t               r_state;
    logic [WIN_CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_pulse_count;
    logic                 r_noise_valid;
    logic                 r_window_done;

    logic                 w_rise;
    logic [CNT_W-1:0]     w_acc_inc;
    logic                 w_decision;

    comp_sync u_comp_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (comp_in),
        .rise_pulse (w_rise)
    );

    // Saturating increment: the all-ones count sticks instead of wrapping.
    assign w_acc_inc = (r_acc == '1) ? r_acc : r_acc + 1'b1;

    always_comb begin
`ifdef NOISE_HYST_EN
        if (r_acc >= THI_C) begin
            w_decision = 1'b1;
        end else if (r_acc < TLO_C) begin
            w_decision = 1'b0;
        end else begin
            w_decision = r_noise_valid;
        end
`else
        w_decision = (r_acc >= THI_C);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cyc         <= '0;
            r_acc         <= '0;
            r_pulse_count <= '0;
            r_noise_valid <= 1'b0;
            r_window_done <= 1'b0;
        end else begin
            r_window_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_acc         <= '0;
                    r_cyc         <= '0;
                    r_noise_valid <= 1'b0;
                    if (enable) begin
                        r_state <= ST_ARM;
                    end
                end

                // Accumulator stays at zero here, so edges from the flush are dropped.
                ST_ARM: begin
                    if (!enable) begin
                        r_state       <= ST_IDLE;
                        r_acc         <= '0;
                        r_noise_valid <= 1'b0;
                    end else if (r_cyc == ARM_LAST_C) begin
                        r_cyc   <= '0;
                        r_state <= ST_COUNT;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end

                ST_COUNT: begin
                    if (!enable) begin
                        r_state       <= ST_IDLE;
                        r_acc         <= '0;
                        r_noise_valid <= 1'b0;
                    end else begin
                        if (w_rise) begin
                            r_acc <= w_acc_inc;
                        end
                        if (r_cyc == WIN_LAST_C) begin
                            r_cyc   <= '0;
                            r_state <= ST_EVAL;
                        end else begin
                            r_cyc <= r_cyc + 1'b1;
                        end
                    end
                end

                // Publishing always completes; a dropped enable only changes
                // where the FSM goes next (noise_valid then clears in IDLE).
                ST_EVAL: begin
                    r_pulse_count <= r_acc;
                    r_noise_valid <= w_decision;
                    r_window_done <= 1'b1;
                    if (enable) begin
                        r_acc   <= w_rise ? CNT_W'(1) : '0;
                        r_state <= ST_COUNT;
                    end else begin
                        r_acc   <= '0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign noise_valid = r_noise_valid;
    assign window_done = r_window_done;
    assign pulse_count = r_pulse_count;
    assign debug_state = r_state;

endmodule

// File: tb/tb_noise_window_detector.sv
// ---------------------------------------------------------------------------
// tb_noise_window_detector
// Two instances share the stimulus: dut (CNT_W=16, THRESH_HI=4, THRESH_LO=2)
// and dut_sat (CNT_W=2, THRESH_HI=2, THRESH_LO=1) to exercise saturation.
// Both use WINDOW_CYCLES=16. Expectations come from the timeline arithmetic
// (enable sampled at edge E: ARM after E, E+1; windows close at E+19+17n)
// and an edge-count model over the recorded comp_in history.
// ---------------------------------------------------------------------------
module tb_noise_window_detector;

`ifdef NOISE_HYST_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        comp_in;
    logic        nv;
    logic        wd;
    logic [15:0] pc;
    logic [1:0]  st;
    logic        nv_s;
    logic        wd_s;
    logic [1:0]  pc_s;
    logic [1:0]  st_s;

    always #5 clk = ~clk;

    noise_window_detector #(
        .WINDOW_CYCLES (16),
        .CNT_W         (16),
        .THRESH_HI     (4),
        .THRESH_LO     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .comp_in     (comp_in),
        .noise_valid (nv),
        .window_done (wd),
        .pulse_count (pc),
        .debug_state (st)
    );

    noise_window_detector #(
        .WINDOW_CYCLES (16),
        .CNT_W         (2),
        .THRESH_HI     (2),
        .THRESH_LO     (1)
    ) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .comp_in     (comp_in),
        .noise_valid (nv_s),
        .window_done (wd_s),
        .pulse_count (pc_s),
        .debug_state (st_s)
    );

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;
    int          edge_no = 0;
    bit          hist [0:4095];
    int          E;
    int          exp_pc;
    int          exp_pcs;
    bit          exp_nv;
    bit          exp_nvs;
    int          win_pc  [0:7];
    int          win_pcs [0:7];
    bit          win_nv  [0:7];

    typedef struct {
        int p   [3];
        int pc  [3];
        int pcs [3];
        bit nvh [3];
        bit nvp [3];
    } win_vec_t;

    win_vec_t tbl [4];

    task automatic chk(input string name, input int got, input int expv);
        vec_cnt++;
        if (got != expv) begin
            err_cnt++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no - 1, got, expv);
        end
    endtask

    task automatic check_outputs(input string tag, input int e_wd, input int e_st,
                                 input int e_pc, input int e_nv, input int e_pcs, input int e_nvs);
        chk({tag, ".window_done"},     int'(wd),   e_wd);
        chk({tag, ".debug_state"},     int'(st),   e_st);
        chk({tag, ".pulse_count"},     int'(pc),   e_pc);
        chk({tag, ".noise_valid"},     int'(nv),   e_nv);
        chk({tag, ".sat.window_done"}, int'(wd_s), e_wd);
        chk({tag, ".sat.debug_state"}, int'(st_s), e_st);
        chk({tag, ".sat.pulse_count"}, int'(pc_s), e_pcs);
        chk({tag, ".sat.noise_valid"}, int'(nv_s), e_nvs);
    endtask

    // Inputs applied here are sampled on the next posedge; outputs are
    // examined 1 time unit after that edge.
    task automatic tick(input bit rst, input bit en, input bit ci);
        reset   = rst;
        enable  = en;
        comp_in = ci;
        @(posedge clk);
        hist[edge_no] = ci;
        edge_no++;
        #1;
    endtask

    // A comp_in rise sampled at edge j (1 at j, 0 at j-1) is counted at j+2.
    // Window 0 counts edges E+3..E+18, window n>=1 counts 17 edges ending at E+18+17n.
    function automatic int model_count(input int e0, input int n, input int cap);
        int lo;
        int hi;
        int c;
        if (n == 0) begin
            lo = e0 + 3;
            hi = e0 + 18;
        end else begin
            lo = e0 + 19 + 17 * (n - 1);
            hi = lo + 16;
        end
        c = 0;
        for (int k = lo; k <= hi; k++) begin
            if (hist[k - 2] && !hist[k - 3]) c++;
        end
        return (c > cap) ? cap : c;
    endfunction

    function automatic bit decide(input int c, input bit prev, input int hi, input int lo);
        if (c >= hi) return 1'b1;
        if (!HYST || c < lo) return 1'b0;
        return prev;
    endfunction

    // Pulse pattern: p[n] one-cycle pulses at even offsets 2..14 of window n.
    function automatic bit pulse_pat(input int d, input int p0, input int p1, input int p2);
        int n;
        int r;
        int np;
        n  = d / 17;
        r  = d % 17;
        np = (n == 0) ? p0 : (n == 1) ? p1 : (n == 2) ? p2 : 0;
        return (r >= 2) && (r % 2 == 0) && ((r - 2) / 2 < np);
    endfunction

    // mode 0: pulse table pattern, 1: random at given density (%), 2: held high
    task automatic run_active(input int nwin, input int mode, input int p0, input int p1,
                              input int p2, input int density);
        int d_last;
        int n;
        int c;
        int cs;
        int e_wd;
        int e_st;
        bit ci;
        E      = edge_no;
        d_last = 19 + 17 * (nwin - 1);
        exp_nv  = 1'b0;
        exp_nvs = 1'b0;
        for (int d = 0; d <= d_last; d++) begin
            case (mode)
                0:       ci = pulse_pat(d, p0, p1, p2);
                1:       ci = (int'($urandom_range(99, 0)) < density);
                default: ci = (d >= 2);
            endcase
            tick(1'b0, 1'b1, ci);
            e_wd = 0;
            if (d >= 19 && (d - 19) % 17 == 0) begin
                n       = (d - 19) / 17;
                c       = model_count(E, n, 65535);
                cs      = model_count(E, n, 3);
                exp_nv  = decide(c, exp_nv, 4, 2);
                exp_nvs = decide(cs, exp_nvs, 2, 1);
                exp_pc  = c;
                exp_pcs = cs;
                e_wd    = 1;
                win_pc[n]  = int'(pc);
                win_pcs[n] = int'(pc_s);
                win_nv[n]  = nv;
            end
            e_st = (d < 2) ? 1 : (((d - 2) % 17 == 16) ? 3 : 2);
            check_outputs("run", e_wd, e_st, exp_pc, int'(exp_nv), exp_pcs, int'(exp_nvs));
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            check_outputs("idle", 0, 0, exp_pc, 0, exp_pcs, 0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        comp_in = 1'b0;

        tbl[0] = '{'{5, 3, 1}, '{5, 3, 1}, '{3, 3, 1}, '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b0}};
        tbl[1] = '{'{0, 4, 2}, '{0, 4, 2}, '{0, 3, 2}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b0}};
        tbl[2] = '{'{7, 0, 3}, '{7, 0, 3}, '{3, 0, 3}, '{1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0}};
        tbl[3] = '{'{6, 2, 1}, '{6, 2, 1}, '{3, 2, 1}, '{1'b1, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b0}};

        // Reset state
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        exp_pc  = 0;
        exp_pcs = 0;
        check_outputs("reset", 0, 0, 0, 0, 0, 0);
        idle(3);

        // Table-driven three-window runs
        for (int t = 0; t < 4; t++) begin
            run_active(3, 0, tbl[t].p[0], tbl[t].p[1], tbl[t].p[2], 0);
            for (int w = 0; w < 3; w++) begin
                chk("table.pulse_count", win_pc[w], tbl[t].pc[w]);
                chk("table.sat_pulse_count", win_pcs[w], tbl[t].pcs[w]);
                chk("table.noise_valid", int'(win_nv[w]),
                    HYST ? int'(tbl[t].nvh[w]) : int'(tbl[t].nvp[w]));
            end
            idle(3);
        end

        // comp_in held high: a single rising edge per window
        run_active(2, 2, 0, 0, 0, 0);
        chk("held.window0", win_pc[0], 1);
        chk("held.window1", win_pc[1], 0);
        idle(3);

        // enable dropped on COUNT cycle 8 with 3 pulses seen
        for (int d = 0; d <= 9; d++) tick(1'b0, 1'b1, pulse_pat(d, 3, 0, 0));
        tick(1'b0, 1'b0, 1'b0);
        check_outputs("drop_count", 0, 0, 0, 0, 0, 0);
        idle(20);
        run_active(1, 0, 2, 0, 0, 0);
        chk("after_drop.pulse_count", win_pc[0], 2);
        idle(3);

        // enable dropped during EVAL: updates land, noise_valid clears a cycle later
        for (int d = 0; d <= 18; d++) tick(1'b0, 1'b1, pulse_pat(d, 5, 0, 0));
        tick(1'b0, 1'b0, 1'b0);
        exp_pc  = 5;
        exp_pcs = 3;
        check_outputs("drop_eval", 1, 0, 5, 1, 3, 1);
        tick(1'b0, 1'b0, 1'b0);
        check_outputs("drop_eval_next", 0, 0, 5, 0, 3, 0);
        idle(3);

        // Reset mid-window, enable held high throughout
        for (int d = 0; d <= 9; d++) tick(1'b0, 1'b1, pulse_pat(d, 3, 0, 0));
        tick(1'b1, 1'b1, 1'b0);
        exp_pc  = 0;
        exp_pcs = 0;
        check_outputs("mid_reset", 0, 0, 0, 0, 0, 0);
        run_active(1, 0, 2, 0, 0, 0);
        chk("after_reset.pulse_count", win_pc[0], 2);
        idle(3);

        // Randomized comp_in against the history model
        run_active(6, 1, 0, 0, 0, 20);
        idle(3);
        run_active(6, 1, 0, 0, 0, 45);
        idle(3);
        run_active(6, 1, 0, 0, 0, 70);
        idle(3);
        run_active(6, 1, 0, 0, 0, 95);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/noise_window_detector.md
NOISE_WINDOW_DETECTOR -- requirements
Module: noise_window_detector

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter WINDOW_CYCLES, default 1000: length of the counting window in clk cycles (legal range 4..65535).
REQ-003 Parameter CNT_W, default 16: width of the pulse counter and the thresholds.
REQ-004 Parameter THRESH_HI, default 8: minimum pulse count that sets noise_valid.
REQ-005 Parameter THRESH_LO, default 4: count below which noise_valid clears; used only with hysteresis enabled.
REQ-006 Port clk, input, 1: system clock.
REQ-007 Port reset, input, 1: synchronous reset, active-high.
REQ-008 Port enable, input, 1: run request; level-sensitive.
REQ-009 Port comp_in, input, 1: raw diode comparator output; asynchronous to clk.
REQ-010 Port noise_valid, output, 1: registered noise decision; this output feeds the controller's noise input.
REQ-011 Port window_done, output, 1: one-cycle strobe marking the cycle on which the decision updates.
REQ-012 Port pulse_count, output, CNT_W: rising-edge count of the last completed window.
REQ-013 Port debug_state, output, 2: current FSM state encoding.

Function
REQ-014 comp_in SHALL pass through a 2-flop synchroniser and a rising-edge detector; an edge SHALL be counted 3 clk cycles after the comp_in rise.
REQ-015 The FSM SHALL have the states IDLE=0, ARM=1, COUNT=2 and EVAL=3.
REQ-016 IDLE SHALL move to ARM when enable=1.
REQ-017 ARM SHALL last exactly 2 cycles to flush the synchroniser, then move to COUNT, discarding any edges seen during ARM.
REQ-018 COUNT SHALL last exactly WINDOW_CYCLES cycles and add 1 to the pulse accumulator for each detected edge.
REQ-019 The accumulator SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 EVAL SHALL last 1 cycle, during which it:
- copies the accumulator into pulse_count;
- updates noise_valid;
- asserts window_done;
- reloads the accumulator with 1 if an edge is detected in that cycle, otherwise 0;
- returns to COUNT.
REQ-021 An edge on the final COUNT cycle SHALL be included in the window being closed.
REQ-022 If enable=0 in any non-IDLE state, the block SHALL go to IDLE on the next cycle, clear the accumulator and noise_valid, and leave pulse_count unchanged.
REQ-023 If enable=0 during EVAL, EVAL's updates SHALL still complete in that cycle, and noise_valid SHALL clear one cycle later.
REQ-024 The threshold comparison SHALL be unsigned, CNT_W wide.

Reset
REQ-025 reset SHALL take priority over every other input.
REQ-026 Reset values: state=IDLE, noise_valid=0, window_done=0, pulse_count=0, accumulator=0, synchroniser flops=0.
REQ-027 Reset asserted mid-window SHALL discard that window entirely; no window_done SHALL be produced for it.

Configuration
REQ-028 Macro NOISE_HYST_EN SHALL select the hysteresis feature.
REQ-029 With NOISE_HYST_EN defined:
- noise_valid sets when count >= THRESH_HI;
- noise_valid clears when count < THRESH_LO;
- otherwise noise_valid holds its value.
REQ-030 Without NOISE_HYST_EN: noise_valid = (count >= THRESH_HI); THRESH_LO SHALL be ignored.

Structure
REQ-031 Package noise_pkg SHALL hold the state encoding constants and the default width and threshold constants.
REQ-032 Synchronisation and edge detection SHALL be a sub-module, comp_sync (inputs clk, reset, async_in; output rise_pulse).
REQ-033 The FSM, window counter, accumulator and decision logic SHALL reside in the top module.

Verification
All scenarios use WINDOW_CYCLES=16, THRESH_HI=4, THRESH_LO=2.
REQ-034 Enable high with 5 comp_in pulses in the first window -> window_done at cycle 19 after enable, pulse_count=5, noise_valid=1.
REQ-035 Window counts 5, 3, 1 with hysteresis on -> noise_valid 1, 1, 0; with hysteresis off -> 1, 0, 0.
REQ-036 comp_in held at 1 for a whole window -> pulse_count=1, since only rising edges count.
REQ-037 CNT_W=2 with 6 pulses in one window -> pulse_count=3, saturated with no wrap.
REQ-038 enable dropped at COUNT cycle 8 with 3 pulses seen -> IDLE the next cycle, noise_valid=0, no window_done, pulse_count unchanged.
REQ-039 reset held for 1 cycle mid-window -> every output at its reset value the next cycle; a fresh ARM follows while enable stays high.
